booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised, iterative radix-2 Booth multiplier. Successor to the combinational 16x16 Booth multiplier.
- Trades area for latency: one Booth step per cycle.
- Adds a per-operation signed/unsigned mode and a valid/ready handshake on both input and output.
- Used by CNN datapath units where a full-array multiplier is too large, and where stalls from downstream accumulators must be absorbed.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits; legal range 4..32.
- CNT_W, $clog2(WIDTH+2), step-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands and mode valid
- in_ready  output  1  block can accept operands
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned
- multiplicand  input  WIDTH  operand A
- multiplier  input  WIDTH  operand B
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  A*B, interpreted per the latched mode
- busy  output  1  high in CALC or DONE

Behaviour:
- Single clock domain. Reset is synchronous and active-low: sampled only on the rising edge of clk while rst_n=0.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - product = 0, all internal registers = 0.
- FSM states:
  - IDLE: in_ready = 1. When in_valid=1 at an edge, latch operands and mode, then go to CALC.
  - CALC: in_ready = 0. Perform one Booth step per edge. After step WIDTH+1, go to DONE.
  - DONE: out_valid = 1, product held stable. When out_ready=1 at an edge, go to IDLE.
  - No new operand is accepted in DONE, even if out_ready=1 in the same cycle; there are no back-to-back overlapped operations.
- Operand extension at load:
  - A and B are extended to WIDTH+1 bits: sign-extended if is_signed=1, zero-extended otherwise.
  - Accumulator = 0, Q = extended B, Q(-1) = 0, counter = 0.
- Booth step on {Q[0], Q(-1)}:
  - 01: acc += extA.
  - 10: acc -= extA.
  - 00 / 11: no add.
  - Then arithmetic right shift of {acc, Q, Q(-1)} by one; counter increments.
- Result:
  - The low 2*WIDTH bits of {acc, Q} after WIDTH+1 steps.
  - Exact for all operand values in both modes: no overflow and no saturation. Covers signed min*min, and unsigned max*max.
- Latency:
  - Handshake on edge E0 → steps on edges E0+1 .. E0+WIDTH+1.
  - product and out_valid are registered at edge E0+WIDTH+1.
  - Latency is fixed and data-independent, including zero operands.
- Handshake rules:
  - in_valid may drop while busy; it is ignored outside IDLE.
  - product and out_valid stay unchanged while out_valid=1 and out_ready=0, for an unbounded number of cycles.
  - out_valid is deasserted on the edge where out_ready=1 is sampled.
  - product keeps its last value until the next DONE entry.
- Input stability: operands and is_signed only need to be stable on the accept edge; later changes have no effect on the operation in flight.
- Reset mid-operation: rst_n=0 in CALC or DONE returns to the reset state on that edge. The in-flight result is discarded and no out_valid pulse is produced.
- out_ready is ignored outside DONE.

Test Plan:
- WIDTH=16, signed, A=100, B=12 → out_valid rises exactly 17 edges after accept; product = 32'd1200; in_ready = 0 throughout CALC and DONE.
- WIDTH=16, signed, A=-3 (16'hFFFD), B=7 → product = 32'hFFFFFFEB. Same operands with is_signed=0 → product = 65533*7 = 32'h0006FFEB.
- WIDTH=16, extremes:
  - signed A=B=16'h8000 → 32'h40000000.
  - unsigned A=B=16'hFFFF → 32'hFFFE0001.
  - A=0, B=5 → 32'd0 with unchanged latency.
- Backpressure: A=85, B=30; hold out_ready=0 for 6 cycles after out_valid → product stays 32'd2550 and out_valid stays 1. Changes to in_valid/operands during the stall are ignored. Raising out_ready → IDLE next edge; the next operation (90*4) yields 32'd360.
- Reset mid-operation: assert rst_n=0 for 1 edge at step 5 of a calculation → next cycle state is IDLE, in_ready = 1, out_valid = 0, product = 0. A following 7*6 completes with 32'd42.
- WIDTH=8 instance, signed, A=-128, B=127 → product = 16'hC080 after 9 step edges. Unsigned A=255, B=255 → 16'hFE01.

Source files
------------

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - iterative radix-2 Booth multiplier with valid/ready handshake
module booth_mult_seq #(
   parameter  int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

   state_t           state;
   state_t           state_next;
   logic [WIDTH:0]   ext_a;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   q;
   logic             q_m1;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   acc_sh;
   logic [WIDTH:0]   q_sh;
   logic             last_step;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign last_step = (cnt == LAST_STEP);

   // State register; reset wins over any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic: accept only in IDLE, finish after WIDTH+1 steps, release on out_ready.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = CALC;
         CALC:    if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One Booth step: add/subtract the extended multiplicand, then arithmetic shift {acc, q, q_m1}.
   always_comb begin
      sum = acc;
      case ({q[0], q_m1})
         2'b01:   sum = acc + ext_a;
         2'b10:   sum = acc - ext_a;
         default: sum = acc;
      endcase
      acc_sh = {sum[WIDTH], sum[WIDTH:1]};
      q_sh   = {sum[0], q[WIDTH:1]};
   end

   // Datapath: operands extended to WIDTH+1 bits so min*min and max*max stay exact.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ext_a   <= '0;
         acc     <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ext_a <= {is_signed & multiplicand[WIDTH-1], multiplicand};
                  q     <= {is_signed & multiplier[WIDTH-1], multiplier};
                  acc   <= '0;
                  q_m1  <= 1'b0;
                  cnt   <= '0;
               end
            end
            CALC: begin
               acc  <= acc_sh;
               q    <= q_sh;
               q_m1 <= q[0];
               cnt  <= cnt + CNT_W'(1);
               if (last_step) product <= {acc_sh[WIDTH-2:0], q_sh};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq (WIDTH=16 and WIDTH=8)
module tb_booth_mult_seq;

   typedef struct {
      logic        s;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec16_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        is_signed = 1'b0;
   logic [15:0] multiplicand = '0;
   logic [15:0] multiplier = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] product;
   logic        busy;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic        is_signed8 = 1'b0;
   logic [7:0]  multiplicand8 = '0;
   logic [7:0]  multiplier8 = '0;
   logic        out_valid8;
   logic        out_ready8 = 1'b0;
   logic [15:0] product8;
   logic        busy8;

   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] sb[$];

   booth_mult_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .is_signed(is_signed), .multiplicand(multiplicand), .multiplier(multiplier),
      .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
   );

   booth_mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .is_signed(is_signed8), .multiplicand(multiplicand8), .multiplier(multiplier8),
      .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model16(input logic s, input logic [15:0] a, input logic [15:0] b);
      int sa;
      int sb_;
      if (s) begin
         sa  = int'($signed(a));
         sb_ = int'($signed(b));
         return 32'(sa * sb_);
      end
      return {16'h0, a} * {16'h0, b};
   endfunction

   // Run one 16-bit operation: accept, latency check, optional stall with disturbing inputs, release.
   task automatic op16(input string name, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input int stall);
      int          n;
      int          w;
      logic        rdy_low;
      logic        stable;
      logic [31:0] held;
      logic [31:0] e;
      w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; is_signed = s; multiplicand = a; multiplier = b;
      tick();
      sb.push_back(exp);
      in_valid = 1'b0;
      is_signed = ~s; multiplicand = 16'($urandom); multiplier = 16'($urandom);
      n = 0; rdy_low = 1'b1;
      while (n < 40) begin
         if (in_ready) rdy_low = 1'b0;
         if (out_valid) break;
         tick(); n++;
      end
      check({name, "_latency"}, 64'(n), 64'd17);
      check({name, "_in_ready_low"}, 64'(rdy_low), 64'd1);
      held = product;
      e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
      check({name, "_product"}, 64'(product), 64'(e));
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; multiplicand = 16'($urandom); multiplier = 16'($urandom);
         tick();
         if (!out_valid || product !== held || in_ready) stable = 1'b0;
      end
      in_valid = 1'b0;
      if (stall > 0) check({name, "_stall_hold"}, 64'(stable), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({name, "_released"}, {62'd0, out_valid, in_ready}, 64'd1);
      check({name, "_product_kept"}, 64'(product), 64'(held));
   endtask

   task automatic op8(input string name, input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
      int n;
      in_valid8 = 1'b1; is_signed8 = s; multiplicand8 = a; multiplier8 = b;
      tick();
      in_valid8 = 1'b0; multiplicand8 = 8'($urandom); multiplier8 = 8'($urandom);
      n = 0;
      while (n < 30 && !out_valid8) begin tick(); n++; end
      check({name, "_latency"}, 64'(n), 64'd9);
      check({name, "_product"}, 64'(product8), 64'(exp));
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      check({name, "_released"}, {62'd0, out_valid8, in_ready8}, 64'd1);
   endtask

   initial begin
      vec16_t vt[$];
      logic   ok;
      int     n;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;

      vt.push_back('{1'b1, 16'd100,   16'd12,   32'd1200});
      vt.push_back('{1'b1, 16'hFFFD,  16'd7,    32'hFFFFFFEB});
      vt.push_back('{1'b0, 16'hFFFD,  16'd7,    32'h0006FFEB});
      vt.push_back('{1'b1, 16'h8000,  16'h8000, 32'h40000000});
      vt.push_back('{1'b0, 16'hFFFF,  16'hFFFF, 32'hFFFE0001});
      vt.push_back('{1'b1, 16'd0,     16'd5,    32'd0});
      vt.push_back('{1'b1, 16'h7FFF,  16'h8000, 32'hC0008000});
      vt.push_back('{1'b1, 16'hFFFF,  16'hFFFF, 32'd1});

      repeat (3) tick();
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_product", 64'(product), 64'd0);
      rst_n = 1'b1;
      tick();

      foreach (vt[i]) op16($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].exp, 0);

      for (int i = 0; i < 6; i++) begin
         rs = 1'($urandom); ra = 16'($urandom); rb = 16'($urandom);
         op16($sformatf("rnd%0d", i), rs, ra, rb, model16(rs, ra, rb), i % 3);
      end

      op16("stall_85x30", 1'b1, 16'd85, 16'd30, 32'd2550, 6);
      op16("after_stall_90x4", 1'b1, 16'd90, 16'd4, 32'd360, 0);

      // Reset during CALC: after step 5, one reset edge, then no output may appear.
      in_valid = 1'b1; is_signed = 1'b1; multiplicand = 16'd1234; multiplier = 16'd4321;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check("midrst_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_state", {60'd0, in_ready, out_valid, busy, 1'b0}, {60'd0, 4'b1000});
      check("midrst_product", 64'(product), 64'd0);
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin tick(); if (out_valid) ok = 1'b0; end
      check("midrst_no_out_valid", 64'(ok), 64'd1);
      op16("after_rst_7x6", 1'b1, 16'd7, 16'd6, 32'd42, 0);

      // out_ready asserted in IDLE must not matter; DONE must not accept a new operand.
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("idle_out_ready_ignored", {62'd0, out_valid, in_ready}, 64'd1);
      in_valid = 1'b1; is_signed = 1'b0; multiplicand = 16'd3; multiplier = 16'd5;
      tick();
      n = 0;
      while (n < 40 && !out_valid) begin tick(); n++; end
      multiplicand = 16'd9; multiplier = 16'd9;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("done_no_accept", {62'd0, busy, in_ready}, 64'd1);
      check("done_product", 64'(product), 64'd15);

      op8("w8_signed", 1'b1, 8'h80, 8'd127, 16'hC080);
      op8("w8_unsigned", 1'b0, 8'd255, 8'd255, 16'hFE01);
      op8("w8_min_min", 1'b1, 8'h80, 8'h80, 16'h4000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
